sccb_writer: RTL and testbench

Consumer end of the camera configuration stream. It accepts 16-bit {register address, register data} words over a valid/ready handshake and serialises each one as a 3-phase SCCB write to the OV7670 (device ID, register address, data). It sits between the configuration word source and the SIOC/SIOD pads. Each transaction is followed by a programmable settle gap before the next word is accepted.

---
 rtl/sccb_writer.sv | 174 +++++++++++++++++
 tb/tb_sccb_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_writer.sv
// sccb_writer: accepts {register address, register data} words over a valid/ready
// handshake. Each word goes out as a 3-phase SCCB write (device ID, address, data)
// on SIOC/SIOD, and every transaction is followed by an idle settle gap.
module sccb_writer #(
  parameter int unsigned CLK_DIV    = 250,    // clk cycles per SCCB quarter-bit (>= 2)
  parameter logic [7:0]  DEV_ID     = 8'h42,  // SCCB write ID byte
  parameter int unsigned GAP_CYCLES = 1000    // idle cycles after STOP (>= 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] din,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  output logic        busy,
  output logic [7:0]  tx_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       LAST_BIT = 5'd26;  // 3 bytes x 9 slots
  localparam logic [3:0]       ACK_SLOT = 4'd8;   // 9th slot of each byte

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       quarter_q;
  logic [1:0]       quarter_d;
  logic [4:0]       bit_q;
  logic [3:0]       slot_q;
  logic [23:0]      shift_q;
  logic [GAP_W-1:0] gap_q;
  logic             s_ready_q;
  logic             busy_q;
  logic             sioc_q;
  logic             siod_q;
  logic             siod_oe_q;
  logic [7:0]       tx_count_q;
  logic             running;
  logic             tick;

  // The quarter divider only runs while a transaction is on the wire.
  assign running   = (state_q == S_START) || (state_q == S_BITS) || (state_q == S_STOP);
  assign tick      = (div_q == DIV_LAST);
  assign quarter_d = quarter_q + 2'd1;

  assign s_ready  = s_ready_q;
  assign busy     = busy_q;
  assign sioc     = sioc_q;
  assign siod_o   = siod_q;
  assign siod_oe  = siod_oe_q;
  assign tx_count = tx_count_q;

  // Transaction FSM: every output is registered and updated as each quarter is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, the shift word included, is reset so an aborted word
    // leaves nothing behind and the pads return to idle the moment rst_n falls.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      quarter_q  <= '0;
      bit_q      <= '0;
      slot_q     <= '0;
      shift_q    <= '0;
      gap_q      <= '0;
      s_ready_q  <= 1'b1;
      busy_q     <= 1'b0;
      sioc_q     <= 1'b1;
      siod_q     <= 1'b1;
      siod_oe_q  <= 1'b1;
      tx_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the
      // pre-edge register values regardless of statement order.
      if (running) begin
        div_q <= tick ? '0 : div_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (s_valid && s_ready_q) begin
            state_q   <= S_START;
            shift_q   <= {DEV_ID, din};
            div_q     <= '0;
            quarter_q <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            quarter_q <= quarter_d;
            case (quarter_q)
              2'd0:    siod_q <= 1'b0;   // start condition, SIOC still high
              2'd2:    sioc_q <= 1'b0;
              2'd3: begin
                state_q <= S_BITS;
                bit_q   <= '0;
                slot_q  <= '0;
              end
              default: ;
            endcase
          end
        end

        S_BITS: begin
          if (tick) begin
            quarter_q <= quarter_d;
            case (quarter_q)
              2'd0: begin
                // Present the next bit while SIOC is low; the 9th slot releases SIOD.
                if (slot_q == ACK_SLOT) begin
                  siod_oe_q <= 1'b0;
                end else begin
                  siod_oe_q <= 1'b1;
                  siod_q    <= shift_q[23];
                  shift_q   <= {shift_q[22:0], 1'b0};
                end
              end
              2'd1:    sioc_q <= 1'b1;
              2'd3: begin
                sioc_q <= 1'b0;
                if (bit_q == LAST_BIT) begin
                  state_q   <= S_STOP;
                  siod_oe_q <= 1'b1;
                  siod_q    <= 1'b0;
                end else begin
                  bit_q  <= bit_q + 5'd1;
                  slot_q <= (slot_q == ACK_SLOT) ? 4'd0 : slot_q + 4'd1;
                end
              end
              default: ;
            endcase
          end
        end

        S_STOP: begin
          if (tick) begin
            quarter_q <= quarter_d;
            case (quarter_q)
              2'd0:    sioc_q <= 1'b1;
              2'd1:    siod_q <= 1'b1;   // stop condition, SIOC high
              2'd3: begin
                state_q    <= S_GAP;
                gap_q      <= '0;
                tx_count_q <= tx_count_q + 8'd1;
              end
              default: ;
            endcase
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q   <= S_IDLE;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_writer.sv
// Directed bench for sccb_writer with CLK_DIV=2, GAP_CYCLES=4. A bus monitor
// decodes SIOC/SIOD into frames and compares them in order against the words
// the driver saw accepted.
module tb_sccb_writer;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned GAP_CYCLES = 4;
  localparam logic [7:0]  DEV_ID     = 8'h42;
  localparam int          BUDGET     = 2000;
  // 116 quarters of transaction plus the gap
  localparam int          TXN_EDGES  = 116 * CLK_DIV + GAP_CYCLES;
  // Slot pattern: 8 driven bits then one released slot, three times.
  localparam logic [26:0] OE_MASK    = 27'b111111110_111111110_111111110;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        s_valid;
  logic        s_ready;
  logic        sioc;
  logic        siod_o;
  logic        siod_oe;
  logic        busy;
  logic [7:0]  tx_count;

  sccb_writer #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ID    (DEV_ID),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .sioc    (sioc),
    .siod_o  (siod_o),
    .siod_oe (siod_oe),
    .busy    (busy),
    .tx_count(tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int frames   = 0;

  logic [15:0] exp_q[$];

  always @(posedge clk) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: SIOD as seen on the wire (pull-up when released), sampled mid-cycle.
  logic        line;
  logic        sioc_prev = 1'b1;
  logic        line_prev = 1'b1;
  logic        in_frame  = 1'b0;
  int          nbits     = 0;
  logic [26:0] dbits;
  logic [26:0] obits;
  logic [15:0] exp_w;

  assign line = siod_oe ? siod_o : 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      nbits    = 0;
    end else begin
      if (in_frame && sioc && !sioc_prev) begin
        if (nbits < 27) begin
          dbits = {dbits[25:0], line};
          obits = {obits[25:0], siod_oe};
        end
        nbits++;
      end
      if (sioc && sioc_prev && line_prev && !line) begin
        in_frame = 1'b1;
        nbits    = 0;
      end
      if (sioc && sioc_prev && !line_prev && line && in_frame) begin
        in_frame = 1'b0;
        frames++;
        // 27 bit slots plus the SIOC rise that opens the STOP sequence
        check("frame_len", nbits, 28);
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("frame_data", {8'h00, dbits[26:19], dbits[17:10], dbits[8:1]},
                {8'h00, DEV_ID, exp_w});
          check("frame_oe", {5'd0, obits}, {5'd0, OE_MASK});
        end
      end
    end
    sioc_prev = sioc;
    line_prev = line;
  end

  // Present a word and hold it until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    din     = w;
    s_valid = 1'b1;
    while (!s_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 0, 1);
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(w);
      @(negedge clk);
      s_valid  = 1'b0;
      acc_edge = edge_cnt;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!s_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, s_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    din     = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sioc", sioc, 1);
    check("rst_siod", siod_o, 1);
    check("rst_oe", siod_oe, 1);
    check("rst_txcnt", tx_count, 0);

    // Released with no traffic: idle persists
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_ready", s_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_sioc", sioc, 1);
    check("idle_siod", line, 1);

    // Single word 0x1280
    send(16'h1280);
    check("acc_busy", busy, 1);
    check("acc_ready", s_ready, 0);
    check("start_q0_siod", siod_o, 1);
    @(negedge clk);
    check("start_q0_hold", siod_o, 1);
    @(negedge clk);
    check("start_fall_siod", siod_o, 0);
    check("start_fall_sioc", sioc, 1);
    wait_ready("single_done");
    check("ready_return", edge_cnt - acc_edge, TXN_EDGES);
    check("single_txcnt", tx_count, 1);
    check("single_frames", frames, 1);

    // s_valid held high with din changing while busy
    @(negedge clk);
    din     = 16'h3456;
    s_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(16'h3456);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!s_ready) din = 16'hA000 + n[15:0];
    end while (!s_ready && n < BUDGET);
    check("hold_ready", s_ready, 1);
    din = 16'h789A;
    @(posedge clk);
    exp_q.push_back(16'h789A);
    @(negedge clk);
    s_valid = 1'b0;
    wait_ready("hold_done");
    check("hold_txcnt", tx_count, 3);
    check("hold_frames", frames, 3);

    // Reset pulse during bit 10 of a transaction
    send(16'h5511);
    repeat (92) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sioc", sioc, 1);
    check("abort_siod", siod_o, 1);
    check("abort_oe", siod_oe, 1);
    check("abort_ready", s_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_txcnt", tx_count, 0);
    exp_q.delete();
    @(negedge clk);
    check("abort_frames", frames, 3);
    #2;
    rst_n = 1'b1;
    send(16'h0D0E);
    wait_ready("post_abort_done");
    check("post_abort_txcnt", tx_count, 1);
    check("post_abort_frames", frames, 4);

    // Back-to-back stream through to the tx_count wrap
    for (int i = 0; i < 121; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send({b + 8'h10, b ^ 8'hA5});
    end
    wait_ready("stream122_done");
    check("stream122_txcnt", tx_count, 122);
    check("stream122_frames", frames, 125);
    for (int i = 121; i < 254; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send({b + 8'h10, b ^ 8'hA5});
    end
    wait_ready("stream255_done");
    check("stream255_txcnt", tx_count, 255);
    send(16'hFF00);
    wait_ready("wrap_done");
    check("wrap_txcnt", tx_count, 0);
    check("total_frames", frames, 259);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
